// File: rtl/fifo_flex.sv
// fifo_flex: single-clock ready/valid FIFO, registered-read or FWFT, thresholds, level, flush; FIFO_FLEX_ERR_FLAGS_EN adds sticky overflow/underflow
module fifo_flex #(
  parameter int DEPTH     = 10,
  parameter int WIDTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [WIDTH-1:0]             enq_data,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [WIDTH-1:0]             deq_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTRW-1:0]  w_wr_nxt, w_rd_nxt;
  logic [CNTW-1:0]  r_level;
  logic             w_full, w_empty, w_do_enq, w_do_deq;
  assign w_full       = r_level == CNTW'(DEPTH);
  assign w_empty      = r_level == '0;
  assign w_do_enq     = enq_valid && !w_full;
  assign w_do_deq     = deq_ready && !w_empty;
  assign w_wr_nxt     = (r_wr_ptr == PTRW'(DEPTH - 1)) ? '0 : r_wr_ptr + PTRW'(1);
  assign w_rd_nxt     = (r_rd_ptr == PTRW'(DEPTH - 1)) ? '0 : r_rd_ptr + PTRW'(1);
  assign enq_ready    = !w_full;
  assign deq_valid    = !w_empty;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = r_level >= CNTW'(AF_THRESH);
  assign almost_empty = r_level <= CNTW'(AE_THRESH);
  assign level        = r_level;
  // pointers and occupancy; flush discards any same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= w_do_enq ? w_wr_nxt : r_wr_ptr;
      r_rd_ptr <= w_do_deq ? w_rd_nxt : r_rd_ptr;
      r_level  <= r_level + CNTW'(w_do_enq) - CNTW'(w_do_deq);
    end
  end
  // storage is never reset; writes suppressed during rst/flush
  always_ff @(posedge clk) begin
    if (w_do_enq && !rst && !flush) r_mem[r_wr_ptr] <= enq_data;
  end
  generate
    if (FWFT != 0) begin : g_fwft
      assign deq_data = r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_deq_data;
      // registered read: head word captured on the dequeue handshake
      always_ff @(posedge clk) begin
        if (rst) r_deq_data <= '0;
        else if (w_do_deq && !flush) r_deq_data <= r_mem[r_rd_ptr];
      end
      assign deq_data = r_deq_data;
    end
  endgenerate
`ifdef FIFO_FLEX_ERR_FLAGS_EN
  logic r_ovf, r_unf;
  // sticky error flags, cleared by rst or flush (flush beats a same-cycle set)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (enq_valid & w_full);
      r_unf <= r_unf | (deq_ready & w_empty);
    end
  end
  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: scoreboard bench driving a registered-read and an FWFT fifo_flex with identical stimulus
module tb_fifo_flex;
  logic       clk = 0, rst = 1, flush = 0, enq_valid = 0, deq_ready = 0;
  logic [7:0] enq_data = '0;
  logic       a_enq_ready, a_deq_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_enq_ready, b_deq_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [7:0] a_deq_data, b_deq_data;
  logic [3:0] a_level, b_level;
  int         n_chk = 0, n_err = 0;
  int         m_level = 0;
  logic       m_ovf = 0, m_unf = 0;
  logic [7:0] q0[$], q1[$];
  logic       pend0 = 0;

  always #5 clk = ~clk;

  fifo_flex #(.DEPTH(10), .WIDTH(8), .FWFT(0), .AF_THRESH(8), .AE_THRESH(2)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(a_enq_ready),
    .enq_data(enq_data), .deq_valid(a_deq_valid), .deq_ready(deq_ready), .deq_data(a_deq_data),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_flex #(.DEPTH(10), .WIDTH(8), .FWFT(1), .AF_THRESH(8), .AE_THRESH(2)) u_ff (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(b_enq_ready),
    .enq_data(enq_data), .deq_valid(b_deq_valid), .deq_ready(deq_ready), .deq_data(b_deq_data),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
    .overflow(b_ovf), .underflow(b_unf));

  task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm);
    logic [11:0] exp;
    logic        e_ovf, e_unf;
`ifdef FIFO_FLEX_ERR_FLAGS_EN
    e_ovf = m_ovf;
    e_unf = m_unf;
`else
    e_ovf = 1'b0;
    e_unf = 1'b0;
`endif
    exp = {4'(m_level), m_level == 10, m_level == 0, m_level >= 8, m_level <= 2,
           m_level < 10, m_level > 0, e_ovf, e_unf};
    cmp({nm, " reg"}, {a_level, a_full, a_empty, a_af, a_ae, a_enq_ready, a_deq_valid, a_ovf, a_unf}, exp);
    cmp({nm, " fwft"}, {b_level, b_full, b_empty, b_af, b_ae, b_enq_ready, b_deq_valid, b_ovf, b_unf}, exp);
  endtask

  task automatic cyc(input string nm, input logic ev, input logic [7:0] ed, input logic dr, input logic fl);
    logic acc_e, acc_d;
    enq_valid = ev; enq_data = ed; deq_ready = dr; flush = fl;
    acc_e = ev && m_level < 10 && !fl;
    acc_d = dr && m_level > 0 && !fl;
    if (acc_e) begin
      q0.push_back(ed);
      q1.push_back(ed);
    end
    @(posedge clk); #1;
    if (fl) begin
      m_level = 0; m_ovf = 0; m_unf = 0;
      q0.delete(); q1.delete();
    end else begin
      m_ovf = m_ovf | (ev && m_level == 10);
      m_unf = m_unf | (dr && m_level == 0);
      m_level = m_level + int'(acc_e) - int'(acc_d);
    end
    enq_valid = 0; deq_ready = 0; flush = 0;
    chk(nm);
  endtask

  // monitor: compares read data whenever either DUT hands out a word
  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) cmp("reg data underrun", 12'(a_deq_data), 12'hfff);
      else cmp("reg data", 12'(a_deq_data), 12'(q0.pop_front()));
    end
    pend0 = !rst && !flush && a_deq_valid && deq_ready;
    if (!rst && !flush && b_deq_valid && deq_ready) begin
      if (q1.size() == 0) cmp("fwft data underrun", 12'(b_deq_data), 12'hfff);
      else cmp("fwft data", 12'(b_deq_data), 12'(q1.pop_front()));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset");
    cmp("reset deq_data", 12'(a_deq_data), 12'h000);
    for (int i = 1; i <= 10; i++) cyc("fill", 1, 8'(i), 0, 0);
    cyc("enq when full", 1, 8'hEE, 0, 0);
    cyc("full enq+deq", 1, 8'hEF, 1, 0);
    for (int i = 0; i < 9; i++) cyc("drain", 0, 8'h00, 1, 0);
    cyc("idle", 0, 8'h00, 0, 0);
    cmp("queues drained", 12'(q0.size() + q1.size()), 12'h000);
    cyc("deq when empty", 0, 8'h00, 1, 0);
    cyc("flush clears errors", 0, 8'h00, 0, 1);
    cyc("fwft write", 1, 8'h5A, 0, 0);
    cmp("fwft fall-through", {3'b0, b_deq_valid, b_deq_data}, 12'h15A);
    cyc("to level 2", 1, 8'h5B, 0, 0);
    cyc("to level 3", 1, 8'h5C, 0, 0);
    for (int i = 0; i < 25; i++) cyc("wrap", 1, 8'(8'h20 + i), 1, 0);
    cyc("to level 4", 1, 8'h61, 0, 0);
    cyc("to level 5", 1, 8'h62, 0, 0);
    cyc("flush with enq+deq", 1, 8'hF0, 1, 1);
    cyc("post-flush write", 1, 8'h77, 0, 0);
    cyc("post-flush read", 0, 8'h00, 1, 0);
    cyc("idle", 0, 8'h00, 0, 0);
    cmp("queues drained 2", 12'(q0.size() + q1.size()), 12'h000);
    cmp("reg holds last read", 12'(a_deq_data), 12'h077);
    for (int i = 0; i < 10; i++) cyc("refill", 1, 8'(8'h80 + i), 0, 0);
    cyc("overflow", 1, 8'hEE, 0, 0);
    rst = 1; enq_valid = 1; deq_ready = 1;
    @(posedge clk); #1;
    rst = 0; enq_valid = 0; deq_ready = 0;
    m_level = 0; m_ovf = 0; m_unf = 0; q0.delete(); q1.delete();
    chk("mid-op reset");
    cmp("mid-op reset deq_data", 12'(a_deq_data), 12'h000);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised successor to the team's single-clock ready/valid FIFO. It adds:
- Selectable output mode: registered-read or first-word-fall-through (FWFT).
- Programmable almost-full and almost-empty thresholds.
- An occupancy level output and a synchronous flush.
It sits between producer and consumer stages on the same clock domain.

Parameters:
DEPTH, 10, number of entries (>=2, any value, not restricted to powers of 2)
WIDTH, 8, data width in bits
FWFT, 0, 0 = registered read (deq_data updates the cycle after a dequeue); 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH (range 1..DEPTH)
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (range 0..DEPTH-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous clear of contents
enq_valid  in  1  producer has data
enq_ready  out  1  FIFO can accept, = !full
enq_data  in  WIDTH  write data
deq_valid  out  1  data available, = !empty
deq_ready  in  1  consumer accepts
deq_data  out  WIDTH  read data
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  CNTW  occupancy 0..DEPTH, where CNTW = $clog2(DEPTH+1)
overflow  out  1  sticky error (see Optional Feature)
underflow  out  1  sticky error (see Optional Feature)

Behaviour:
Reset and clear:
- Reset is synchronous, active-high, on rst.
- Reset values: wr_ptr = rd_ptr = 0; level = 0; deq_data = 0 (FWFT=0 only); overflow = underflow = 0.
- After reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Memory contents are not reset.

Handshakes:
- do_enq = enq_valid && enq_ready.
- do_deq = deq_valid && deq_ready.
- enq_valid while full is ignored, with no state change. deq_ready while empty is ignored.
- No combinational path from deq_ready to enq_ready. A full FIFO with a simultaneous dequeue still refuses the enqueue that cycle.

Pointers and level:
- PTRW = (DEPTH<=1) ? 1 : $clog2(DEPTH).
- Each pointer increments on its handshake and wraps from DEPTH-1 to 0, including for non-power-of-2 depths.
- level: +1 on enq only, -1 on deq only, unchanged when both or neither occur.
- All flags and level are driven from the registered level only; no input-to-flag combinational paths.

FWFT=0 (registered read):
- On do_deq, deq_data <= mem[rd_ptr], visible the next cycle.
- deq_data holds its value otherwise.

FWFT=1:
- deq_data = mem[rd_ptr] combinationally, valid whenever deq_valid = 1.
- A write into an empty FIFO makes deq_valid = 1 in the following cycle, with that word on deq_data. Write-to-read latency is 1 cycle.
- deq_data is don't-care while empty.

Simultaneous enq and deq:
- Legal when 0 < level < DEPTH: both pointers advance and level is unchanged.
- When empty, only the enqueue occurs.

Flush:
- Same-cycle priority: rst > flush > enq/deq.
- Flush sets both pointers and level to 0 and discards any same-cycle do_enq and do_deq.
- deq_data holds its value in FWFT=0 mode.
- Flush clears overflow and underflow.

Reset mid-operation: any in-flight enqueue or dequeue in the reset cycle is discarded; outputs take their reset values on the next edge.

Optional Feature:
Macro FIFO_FLEX_ERR_FLAGS_EN.

Defined:
- overflow sets when enq_valid && full.
- underflow sets when deq_ready && empty.
- Both are sticky until rst or flush. If a set condition coincides with flush, flush wins.

Not defined: overflow and underflow are tied to 0 and no error logic is generated. The port list is identical in both builds.

Test Plan:
- DEPTH=10, FWFT=0: enqueue 0x01..0x0A, then dequeue all -> full=1 after 10th write, enq_ready=0; deq_data = 0x01..0x0A in order, each one cycle after its handshake; empty=1 at end.
- DEPTH=10, FWFT=1: write 0x5A into empty -> next cycle deq_valid=1, deq_data=0x5A before any deq_ready.
- Wrap: 25 cycles of simultaneous enq/deq at level 3 -> level stays 3, pointers wrap 9->0, data order preserved.
- AF_THRESH=8, AE_THRESH=2: fill from 0 to 10 -> almost_empty deasserts at level 3, almost_full asserts at level 8.
- Flush at level 5, asserted together with enq_valid and deq_ready -> next cycle level=0, empty=1; the flushed-cycle write is not readable.
- With FIFO_FLEX_ERR_FLAGS_EN defined, enq_valid while full -> overflow=1, level stays 10; rst=1 for one cycle -> overflow=0, level=0.
